// File: rtl/burst_arbiter_pkg.sv
// Shared types and constants for the SDRAM burst arbiter: state encoding,
// owner codes and the default burst geometry.
package burst_arbiter_pkg;

    localparam int BURST_LENGTH     = 9;
    localparam int BURST_ADD_LENGTH = 22;

    // Value burst_length takes out of reset (one full 256-word line).
    localparam int RST_BURST_LENGTH = 256;

    typedef enum logic [3:0] {
        ARB_IDLE  = 4'b0001,
        ARB_ISSUE = 4'b0010,
        ARB_XFER  = 4'b0100,
        ARB_GAP   = 4'b1000
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_WR   = 2'b01;
    localparam logic [1:0] OWN_RD   = 2'b10;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: port b can force a win on a tie, otherwise
// the port that did not own the last burst wins.
module rr_pick2 (
    input  logic req_a,
    input  logic req_b,
    input  logic prio_b,
    input  logic last_b,
    output logic grant_a,
    output logic grant_b
);

    assign grant_a = req_a & (~req_b | (~prio_b & last_b));
    assign grant_b = req_b & ~grant_a;

endmodule

// File: rtl/burst_arbiter.sv
// Shares one SDRAM burst engine between the capture (write) and display (read)
// address managers, one burst per grant, with a hang watchdog.
module burst_arbiter
    import burst_arbiter_pkg::*;
#(
    parameter int LEN_W  = BURST_LENGTH,
    parameter int ADDR_W = BURST_ADD_LENGTH,
    parameter int TMO_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [LEN_W-1:0]  wr_length,
    input  logic [ADDR_W-1:0] wr_address,
    output logic              wr_ack,
    output logic              wr_holda,
    input  logic              rd_req,
    input  logic [LEN_W-1:0]  rd_length,
    input  logic [ADDR_W-1:0] rd_address,
    input  logic              rd_urgent,
    output logic              rd_ack,
    output logic              rd_holda,
    output logic              burst_req,
    output logic              burst_rw,
    output logic [LEN_W-1:0]  burst_length,
    output logic [ADDR_W-1:0] burst_address,
    input  logic              burst_ack,
    input  logic              burst_holda,
    input  logic              burst_done,
    output logic [1:0]        owner,
    output logic              timeout_err
);

    // Abort on the edge where the counter would reach all-ones.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    arb_state_t       state;
    logic             last_rd;
    logic [TMO_W-1:0] tmo_cnt;
    logic             grant_wr, grant_rd;
    logic             in_issue, in_xfer, busy;
    logic             done_hit, tmo_hit, ack_hit;

    rr_pick2 u_pick (
        .req_a   (wr_req),
        .req_b   (rd_req),
        .prio_b  (rd_urgent),
        .last_b  (last_rd),
        .grant_a (grant_wr),
        .grant_b (grant_rd)
    );

    assign in_issue = (state == ARB_ISSUE);
    assign in_xfer  = (state == ARB_XFER);
    assign busy     = in_issue | in_xfer;
    assign done_hit = in_xfer & burst_done;
    assign tmo_hit  = busy & (tmo_cnt == TMO_LAST) & ~done_hit;
    assign ack_hit  = in_issue & burst_ack & ~tmo_hit;

    // Requesters derive read-enable and address from these, so no register stage.
    assign wr_ack   = ack_hit & owner[0];
    assign rd_ack   = ack_hit & owner[1];
    assign wr_holda = in_xfer & burst_holda & owner[0];
    assign rd_holda = in_xfer & burst_holda & owner[1];

    // NOTE: all state here is non-blocking so every register samples the
    // pre-edge values of its peers; there is no memory, so everything is reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ARB_IDLE;
            last_rd       <= 1'b1;
            tmo_cnt       <= '0;
            burst_req     <= 1'b0;
            burst_rw      <= 1'b0;
            burst_length  <= LEN_W'(RST_BURST_LENGTH);
            burst_address <= '0;
            owner         <= OWN_NONE;
            timeout_err   <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    tmo_cnt <= '0;
                    if (grant_wr | grant_rd) begin
                        burst_req     <= 1'b1;
                        burst_rw      <= grant_wr;
                        burst_length  <= grant_wr ? wr_length  : rd_length;
                        burst_address <= grant_wr ? wr_address : rd_address;
                        owner         <= grant_wr ? OWN_WR : OWN_RD;
                        state         <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (tmo_hit) begin
                        burst_req   <= 1'b0;
                        owner       <= OWN_NONE;
                        timeout_err <= 1'b1;
                        state       <= ARB_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (burst_ack) begin
                            burst_req <= 1'b0;
                            last_rd   <= owner[1];
                            state     <= ARB_XFER;
                        end
                    end
                end
                ARB_XFER: begin
                    if (burst_done) begin
                        owner <= OWN_NONE;
                        state <= ARB_GAP;
                    end else if (tmo_hit) begin
                        owner       <= OWN_NONE;
                        timeout_err <= 1'b1;
                        state       <= ARB_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ARB_GAP: begin
                    tmo_cnt <= '0;
                    state   <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
